// File: rtl/edge_pkg.sv
// Shared constants and types for the edge-detect pixel fetch path.
package edge_pkg;

    localparam int PIX_W  = 8;
    localparam int ADDR_W = 32;
    localparam int WIN_N  = 9;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        READ      = 3'd1,
        INC       = 3'd2,
        WAIT_ADDR = 3'd3,
        PRESENT   = 3'd4
    } fetch_state_t;

    typedef logic [PIX_W-1:0]   pixel_t;
    typedef pixel_t [WIN_N-1:0] window_t;

    // Pixel count advance; holds at WIN_N so it can never wrap.
    function automatic logic [CNT_W-1:0] count_advance(input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] nxt;
        if (cnt >= CNT_W'(WIN_N)) begin
            nxt = cnt;
        end else begin
            nxt = cnt + 4'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/window_fetch_if.sv
// Handshake and bus signals between window_fetch and its neighbours.
interface window_fetch_if;
    import edge_pkg::*;

    logic              i_start;
    logic              i_stop;
    logic [ADDR_W-1:0] i_raddr;
    logic              i_r_ready;
    logic              o_inc_raddr;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              o_mem_ren;
    logic [PIX_W-1:0]  i_mem_rdata;
    logic              i_mem_rvalid;
    window_t           o_window;
    logic              o_win_valid;
    logic              i_win_ready;
    logic              o_busy;

    // The fetch block itself.
    modport slave (
        input  i_start, i_stop, i_raddr, i_r_ready,
        input  i_mem_rdata, i_mem_rvalid, i_win_ready,
        output o_inc_raddr, o_mem_addr, o_mem_ren,
        output o_window, o_win_valid, o_busy
    );

    // The environment: controller, address counter, memory and consumer.
    modport master (
        output i_start, i_stop, i_raddr, i_r_ready,
        output i_mem_rdata, i_mem_rvalid, i_win_ready,
        input  o_inc_raddr, o_mem_addr, o_mem_ren,
        input  o_window, o_win_valid, o_busy
    );

endinterface

// File: rtl/window_fetch.sv
// Collects one 3x3 pixel window: read, store, bump the address counter,
// wait for the next address, repeat nine times, then present the window.
module window_fetch
    import edge_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    window_fetch_if.slave  bus
);

    fetch_state_t      state_r;
    fetch_state_t      state_s;
    logic [CNT_W-1:0]  count_r;
    logic [CNT_W-1:0]  count_s;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [ADDR_W-1:0] mem_addr_s;
    logic              store_s;
    window_t           window_r;
    logic              mem_ren_r;
    logic              inc_r;
    logic              win_valid_r;
    logic              busy_r;

    // Next-state, next-count, address latch and pixel-store decode.
    always_comb begin
        state_s    = state_r;
        count_s    = count_r;
        mem_addr_s = mem_addr_r;
        store_s    = 1'b0;
        if (bus.i_stop) begin
            // Abort wins over every transition, including a same-cycle start.
            state_s = IDLE;
            count_s = 4'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.i_start) begin
                        mem_addr_s = bus.i_raddr;
                        state_s    = READ;
                    end else begin
                        state_s    = IDLE;
                    end
                end
                READ: begin
                    if (bus.i_mem_rvalid) begin
                        store_s = 1'b1;
                        count_s = count_advance(count_r);
                        state_s = INC;
                    end else begin
                        state_s = READ;
                    end
                end
                INC: begin
                    state_s = WAIT_ADDR;
                end
                WAIT_ADDR: begin
                    if (bus.i_r_ready) begin
                        mem_addr_s = bus.i_raddr;
                        if (count_r == CNT_W'(WIN_N)) begin
                            state_s = PRESENT;
                        end else begin
                            state_s = READ;
                        end
                    end else begin
                        state_s = WAIT_ADDR;
                    end
                end
                PRESENT: begin
                    if (bus.i_win_ready) begin
                        state_s = IDLE;
                        count_s = 4'd0;
                    end else begin
                        state_s = PRESENT;
                    end
                end
                default: begin
                    state_s = IDLE;
                    count_s = 4'd0;
                end
            endcase
        end
    end

    // State, count and address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            count_r    <= 4'd0;
            mem_addr_r <= '0;
        end else begin
            state_r    <= state_s;
            count_r    <= count_s;
            mem_addr_r <= mem_addr_s;
        end
    end

    // Window slots only change when a returned pixel is stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_r <= '0;
        end else begin
            for (int k = 0; k < WIN_N; k++) begin
                if (store_s && (count_r == CNT_W'(k))) begin
                    window_r[k] <= bus.i_mem_rdata;
                end
            end
        end
    end

    // Status outputs registered from the next state so they track it exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_ren_r   <= 1'b0;
            inc_r       <= 1'b0;
            win_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            mem_ren_r   <= (state_s == READ);
            inc_r       <= (state_s == INC);
            win_valid_r <= (state_s == PRESENT);
            busy_r      <= (state_s != IDLE);
        end
    end

    assign bus.o_mem_addr  = mem_addr_r;
    assign bus.o_mem_ren   = mem_ren_r;
    assign bus.o_inc_raddr = inc_r;
    assign bus.o_win_valid = win_valid_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_window    = window_r;

endmodule

// File: doc/window_fetch.md
Name: window_fetch

Overview:
- Downstream consumer of the address counter's read side. Collects one 3x3 pixel window per request for the edge-detect datapath.
- Per pixel: reads the current read address from pixel memory, stores the returned pixel, then pulses the counter's increment and waits for the next address.
- After 9 pixels, presents the packed window to the compute stage over a valid/ready handshake.

Parameters:
PIX_W, 8, pixel width in bits
ADDR_W, 32, memory address width
WIN_N, 9, pixels per window (3x3; fixed, not for override)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
i_start  in  1  begin fetching one window; sampled only in IDLE
i_stop  in  1  abort; forces IDLE on the next edge
i_raddr  in  ADDR_W  current read address from the address counter
i_r_ready  in  1  one-cycle pulse: i_raddr holds a new valid address
o_inc_raddr  out  1  one-cycle pulse requesting the next read address
o_mem_addr  out  ADDR_W  pixel memory read address
o_mem_ren  out  1  memory read request, held until the data returns
i_mem_rdata  in  PIX_W  memory read data
i_mem_rvalid  in  1  read data valid; honoured only while o_mem_ren=1
o_window  out  WIN_N*PIX_W  packed window; pixel k at [k*PIX_W +: PIX_W], k = row*3 + col
o_win_valid  out  1  window complete and stable
i_win_ready  in  1  consumer accepts the window
o_busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: all outputs 0, o_mem_addr 0, o_window 0, pixel count 0, state IDLE.
- States and transitions:
  - IDLE: if i_start, latch i_raddr into o_mem_addr and go to READ.
  - READ: o_mem_ren=1. When i_mem_rvalid, write i_mem_rdata into slot[count], count+1, go to INC. i_mem_rvalid may arrive in the first READ cycle.
  - INC: o_inc_raddr=1 for exactly one cycle, then go to WAIT_ADDR.
  - WAIT_ADDR: on i_r_ready, latch i_raddr into o_mem_addr. If count==9 go to PRESENT, else go to READ.
  - PRESENT: o_win_valid=1. On i_win_ready, go to IDLE with count cleared.
- Every window issues exactly 9 reads and 9 increments. The 9th increment positions the counter at the start of the next window.
- o_window changes only on a stored pixel. It is stable throughout PRESENT and holds its last value in IDLE.
- Minimum per pixel: READ 1 cycle + INC 1 cycle + WAIT_ADDR (counter latency, 6 cycles nominal) = 8 cycles. Minimum per window: 72 cycles plus 1 cycle in PRESENT.
- o_mem_ren falls on the edge after i_mem_rvalid is sampled; no back-to-back reads.
- i_start outside IDLE is ignored. i_r_ready outside WAIT_ADDR is ignored. i_mem_rvalid outside READ is ignored.
- i_stop has priority over all transitions in any state:
  - next state IDLE, count 0;
  - o_mem_ren, o_inc_raddr and o_win_valid drop on the next edge;
  - o_window is not cleared;
  - rewinding the address counter is the controller's job.
- i_start and i_stop in the same cycle: i_stop wins and the block stays in IDLE.
- Count is 4 bits and saturates by construction (0..9). It is never compared against a wrapped value.
- rst asserted mid-window returns every register to its reset value asynchronously.

Decomposition:
- Shared package edge_pkg holds:
  - PIX_W and WIN_N constants;
  - typedef fetch_state_t (IDLE, READ, INC, WAIT_ADDR, PRESENT);
  - typedef window_t, a packed array of WIN_N pixels.
- No sub-module. Window storage is an indexed register array in this block.

Test Plan:
- Single window: i_raddr sequence 100,101,102,524,525,526,948,949,950, memory returns addr[7:0] -> o_window slot k = those low bytes; exactly 9 o_inc_raddr pulses; o_win_valid at cycle ≥73 after i_start.
- Memory wait states: rvalid delayed 0, 1 and 5 cycles on alternate reads -> o_mem_ren held the full duration; each pixel stored exactly once; no extra increments.
- Backpressure: i_win_ready held low 20 cycles in PRESENT -> o_win_valid stays 1 and o_window unchanged; accept -> IDLE next cycle; o_busy=0.
- Abort: i_stop asserted in WAIT_ADDR after pixel 4 -> IDLE next edge, count 0; subsequent i_r_ready and rvalid ignored; a new i_start refetches 9 pixels cleanly.
- Spurious inputs: i_start pulses while busy and i_r_ready injected during READ -> no effect on the state sequence or addresses.
- Async reset: assert rst mid-READ between clock edges -> o_mem_ren, o_busy and o_win_valid go 0 immediately, before the next clock edge.
